control_pipeline: RTL and testbench

Carries the decoded control word from the ID stage through the EX, MEM and WB pipeline registers of the pipelined RISC core. It is the consumer side of the opcode decoder's control bundle. It also owns pipeline hazard handling:
- load-use stall detection,
- branch-taken flush,
- EX operand forwarding selects.

It sits between the decoder/register-file read (ID) and the datapath stages, and is the only place control bits are staged.

---
 rtl/control_pipeline_pkg.sv | 40 ++++
 rtl/control_pipeline_if.sv | 37 +++
 rtl/control_pipeline_forward_unit.sv | 24 ++
 rtl/control_pipeline.sv | 116 +++++++++++
 tb/tb_control_pipeline.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/control_pipeline_pkg.sv
// Shared control-word types and encodings for the ID/EX/MEM/WB control pipeline.
// Each downstream stage carries only the control bits it or a later stage consumes.
package ctrl_pkg;

  localparam logic [1:0] ALUOP_ADD  = 2'd0;
  localparam logic [1:0] ALUOP_LUI  = 2'd1;
  localparam logic [1:0] ALUOP_FUNC = 2'd2;
  localparam logic [1:0] ALUOP_NOP  = 2'd3;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
  } ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{ALUOP_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam mem_ctrl_t MEM_BUBBLE = '{1'b0, 1'b0, 1'b0, 1'b0};
  localparam wb_ctrl_t WB_BUBBLE = '{1'b0, 1'b0};

endpackage

// File: rtl/control_pipeline_if.sv
// Bundle between the decoder/datapath and the control pipeline.
// The master side drives the decoded ID fields and the branch result.
interface control_pipeline_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [1:0]        ID_ALUOp;
    logic              ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite;
    logic              ID_Branch, ID_ALUSrc, ID_RegDst;
    logic [REG_AW-1:0] ID_Rs, ID_Rt, ID_Rd;
    logic              BranchTaken;

    logic [1:0]        EX_ALUOp;
    logic              EX_ALUSrc, EX_Branch;
    logic              MEM_MemRead, MEM_MemWrite;
    logic              WB_RegWrite, WB_MemtoReg;
    logic [REG_AW-1:0] WB_WriteReg;
    logic [1:0]        ForwardA, ForwardB;
    logic              PCWrite, IFIDWrite, FlushIFID;
    logic [CNT_W-1:0]  StallCount, FlushCount;

    modport master (
        output ID_ALUOp, ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite,
               ID_Branch, ID_ALUSrc, ID_RegDst, ID_Rs, ID_Rt, ID_Rd, BranchTaken,
        input  EX_ALUOp, EX_ALUSrc, EX_Branch, MEM_MemRead, MEM_MemWrite,
               WB_RegWrite, WB_MemtoReg, WB_WriteReg, ForwardA, ForwardB,
               PCWrite, IFIDWrite, FlushIFID, StallCount, FlushCount
    );

    modport slave (
        input  ID_ALUOp, ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite,
               ID_Branch, ID_ALUSrc, ID_RegDst, ID_Rs, ID_Rt, ID_Rd, BranchTaken,
        output EX_ALUOp, EX_ALUSrc, EX_Branch, MEM_MemRead, MEM_MemWrite,
               WB_RegWrite, WB_MemtoReg, WB_WriteReg, ForwardA, ForwardB,
               PCWrite, IFIDWrite, FlushIFID, StallCount, FlushCount
    );
endinterface

// File: rtl/control_pipeline_forward_unit.sv
// EX operand source select for one operand; the younger MEM result wins over WB.
// Register 0 is hard-wired, so writes to it are never forwarded.
module forward_unit
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              mem_rw,
    input  logic [REG_AW-1:0] mem_wr,
    input  logic              wb_rw,
    input  logic [REG_AW-1:0] wb_wr,
    output logic [1:0]        sel
);
    always_comb begin
        // NOTE: default assigned first so every path drives sel and no latch is inferred.
        sel = FWD_RF;
        if (mem_rw && (mem_wr != '0) && (mem_wr == src)) begin
            sel = FWD_MEM;
        end else if (wb_rw && (wb_wr != '0) && (wb_wr == src)) begin
            sel = FWD_WB;
        end
    end
endmodule

// File: rtl/control_pipeline.sv
// Stages decoded control through EX/MEM/WB and owns load-use stall,
// taken-branch flush, EX forwarding selects and saturating event counters.
module control_pipeline
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic               Clk,
    input logic               Reset_n,
    control_pipeline_if.slave bus
);
    ctrl_t             id_ctrl, ex_ctrl;
    mem_ctrl_t         mem_ctrl;
    wb_ctrl_t          wb_ctrl;
    logic [REG_AW-1:0] id_wr, ex_wr, ex_rs, ex_rt, mem_wr, wb_wr;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
    logic              load_use, flush;

    assign id_ctrl = '{alu_op:     bus.ID_ALUOp,
                       reg_write:  bus.ID_RegWrite,
                       mem_to_reg: bus.ID_MemtoReg,
                       mem_read:   bus.ID_MemRead,
                       mem_write:  bus.ID_MemWrite,
                       branch:     bus.ID_Branch,
                       alu_src:    bus.ID_ALUSrc};
    assign id_wr = bus.ID_RegDst ? bus.ID_Rd : bus.ID_Rt;

    // Rt is only a true source when the ALU takes it instead of the immediate.
    assign load_use = ex_ctrl.mem_read && (ex_wr != '0) &&
                      ((ex_wr == bus.ID_Rs) || (!bus.ID_ALUSrc && (ex_wr == bus.ID_Rt)));
    assign flush    = ex_ctrl.branch && bus.BranchTaken;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ex_ctrl <= CTRL_BUBBLE;
            ex_wr   <= '0;
            ex_rs   <= '0;
            ex_rt   <= '0;
        end else if (flush || load_use) begin
            ex_ctrl <= CTRL_BUBBLE;
            ex_wr   <= '0;
            ex_rs   <= '0;
            ex_rt   <= '0;
        end else begin
            // NOTE: non-blocking so every stage register samples its pre-edge source.
            ex_ctrl <= id_ctrl;
            ex_wr   <= id_wr;
            ex_rs   <= bus.ID_Rs;
            ex_rt   <= bus.ID_Rt;
        end
    end

    // MEM and WB always advance; a stall or flush only replaces what enters EX.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mem_ctrl <= MEM_BUBBLE;
            mem_wr   <= '0;
            wb_ctrl  <= WB_BUBBLE;
            wb_wr    <= '0;
        end else begin
            mem_ctrl <= '{reg_write:  ex_ctrl.reg_write,
                          mem_to_reg: ex_ctrl.mem_to_reg,
                          mem_read:   ex_ctrl.mem_read,
                          mem_write:  ex_ctrl.mem_write};
            mem_wr   <= ex_wr;
            wb_ctrl  <= '{reg_write:  mem_ctrl.reg_write,
                          mem_to_reg: mem_ctrl.mem_to_reg};
            wb_wr    <= mem_wr;
        end
    end

    // A flush squashes the dependent instruction too, so it is not also a stall.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (flush) begin
            if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end else if (load_use) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    forward_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .src    (ex_rs),
        .mem_rw (mem_ctrl.reg_write),
        .mem_wr (mem_wr),
        .wb_rw  (wb_ctrl.reg_write),
        .wb_wr  (wb_wr),
        .sel    (bus.ForwardA)
    );

    forward_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .src    (ex_rt),
        .mem_rw (mem_ctrl.reg_write),
        .mem_wr (mem_wr),
        .wb_rw  (wb_ctrl.reg_write),
        .wb_wr  (wb_wr),
        .sel    (bus.ForwardB)
    );

    assign bus.EX_ALUOp     = ex_ctrl.alu_op;
    assign bus.EX_ALUSrc    = ex_ctrl.alu_src;
    assign bus.EX_Branch    = ex_ctrl.branch;
    assign bus.MEM_MemRead  = mem_ctrl.mem_read;
    assign bus.MEM_MemWrite = mem_ctrl.mem_write;
    assign bus.WB_RegWrite  = wb_ctrl.reg_write;
    assign bus.WB_MemtoReg  = wb_ctrl.mem_to_reg;
    assign bus.WB_WriteReg  = wb_wr;
    assign bus.PCWrite      = flush || !load_use;
    assign bus.IFIDWrite    = flush || !load_use;
    assign bus.FlushIFID    = flush;
    assign bus.StallCount   = stall_cnt;
    assign bus.FlushCount   = flush_cnt;
endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline: staging latency, stall, flush, forwarding,
// asynchronous reset and counter saturation (CNT_W reduced to 4 so saturation is reachable).
module tb_control_pipeline;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic Clk;
    logic Reset_n;
    int   compared;
    int   mismatched;

    control_pipeline_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    control_pipeline #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic rw, m2r, mr, mw, br, asrc, rdst,
                         input logic [4:0] rs, rt, rd);
        bus.ID_ALUOp    = op;
        bus.ID_RegWrite = rw;
        bus.ID_MemtoReg = m2r;
        bus.ID_MemRead  = mr;
        bus.ID_MemWrite = mw;
        bus.ID_Branch   = br;
        bus.ID_ALUSrc   = asrc;
        bus.ID_RegDst   = rdst;
        bus.ID_Rs       = rs;
        bus.ID_Rt       = rt;
        bus.ID_Rd       = rd;
    endtask

    task automatic drive_nop();
        drive(2'd3, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic drive_r(input logic [4:0] rs, rt, rd);
        drive(2'd2, 1, 0, 0, 0, 0, 0, 1, rs, rt, rd);
    endtask

    task automatic drive_lw(input logic [4:0] rs, rt);
        drive(2'd0, 1, 1, 1, 0, 0, 1, 0, rs, rt, 5'd0);
    endtask

    task automatic drive_sw(input logic [4:0] rs, rt);
        drive(2'd0, 0, 0, 0, 1, 0, 1, 0, rs, rt, 5'd0);
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        Reset_n     = 1'b0;
        bus.BranchTaken = 1'b0;
        drive_nop();

        // Reset state
        #12;
        check("rst_ex_aluop",  32'(bus.EX_ALUOp), 3);
        check("rst_ex_alusrc", 32'(bus.EX_ALUSrc), 0);
        check("rst_ex_branch", 32'(bus.EX_Branch), 0);
        check("rst_mem_rd",    32'(bus.MEM_MemRead), 0);
        check("rst_mem_wr",    32'(bus.MEM_MemWrite), 0);
        check("rst_wb_rw",     32'(bus.WB_RegWrite), 0);
        check("rst_wb_m2r",    32'(bus.WB_MemtoReg), 0);
        check("rst_wb_reg",    32'(bus.WB_WriteReg), 0);
        check("rst_fwd_a",     32'(bus.ForwardA), 0);
        check("rst_fwd_b",     32'(bus.ForwardB), 0);
        check("rst_pcwrite",   32'(bus.PCWrite), 1);
        check("rst_ifidwrite", 32'(bus.IFIDWrite), 1);
        check("rst_flush",     32'(bus.FlushIFID), 0);
        check("rst_stallcnt",  32'(bus.StallCount), 0);
        check("rst_flushcnt",  32'(bus.FlushCount), 0);
        Reset_n = 1'b1;
        tick();

        // Three independent R-type ops: WB_WriteReg 5, 6, 7 after 3, 4, 5 edges
        drive_r(5'd1, 5'd2, 5'd5);
        tick();
        check("r_ex_aluop", 32'(bus.EX_ALUOp), 2);
        check("r_fwd_a1",   32'(bus.ForwardA), 0);
        drive_r(5'd1, 5'd2, 5'd6);
        tick();
        drive_r(5'd1, 5'd2, 5'd7);
        tick();
        check("r_wb_reg5", 32'(bus.WB_WriteReg), 5);
        check("r_wb_rw",   32'(bus.WB_RegWrite), 1);
        check("r_fwd_a3",  32'(bus.ForwardA), 0);
        check("r_fwd_b3",  32'(bus.ForwardB), 0);
        drive_nop();
        tick();
        check("r_wb_reg6", 32'(bus.WB_WriteReg), 6);
        tick();
        check("r_wb_reg7", 32'(bus.WB_WriteReg), 7);

        // Writes to r0 are never forwarded, from MEM or from WB
        drive_r(5'd1, 5'd2, 5'd0);
        tick();
        drive_r(5'd0, 5'd0, 5'd9);
        tick();
        check("r0_mem_fwd_a", 32'(bus.ForwardA), 0);
        check("r0_mem_fwd_b", 32'(bus.ForwardB), 0);
        drive_nop();
        tick();
        check("r0_wb_fwd_a", 32'(bus.ForwardA), 0);
        tick();
        tick();

        // lw r8 then add using Rs=8: one stall cycle, then forward from WB
        drive_lw(5'd1, 5'd8);
        tick();
        check("lu_ex_aluop_lw", 32'(bus.EX_ALUOp), 0);
        drive_r(5'd8, 5'd2, 5'd9);
        #1;
        check("lu_pcwrite0",   32'(bus.PCWrite), 0);
        check("lu_ifidwrite0", 32'(bus.IFIDWrite), 0);
        check("lu_flush0",     32'(bus.FlushIFID), 0);
        tick();
        check("lu_ex_bubble",  32'(bus.EX_ALUOp), 3);
        check("lu_stallcnt1",  32'(bus.StallCount), 1);
        check("lu_mem_rd",     32'(bus.MEM_MemRead), 1);
        check("lu_pcwrite1",   32'(bus.PCWrite), 1);
        tick();
        check("lu_fwd_a_wb",   32'(bus.ForwardA), 1);
        check("lu_fwd_b_rf",   32'(bus.ForwardB), 0);
        check("lu_wb_m2r",     32'(bus.WB_MemtoReg), 1);
        check("lu_wb_reg8",    32'(bus.WB_WriteReg), 8);
        check("lu_stallcnt_h", 32'(bus.StallCount), 1);
        drive_nop();
        tick();
        tick();
        tick();

        // Operand B forwarded from WB when MEM holds an unrelated bubble
        drive_r(5'd1, 5'd2, 5'd3);
        tick();
        drive_nop();
        tick();
        drive_r(5'd4, 5'd3, 5'd5);
        tick();
        check("wbb_fwd_a", 32'(bus.ForwardA), 0);
        check("wbb_fwd_b", 32'(bus.ForwardB), 1);
        drive_nop();
        tick();
        tick();
        tick();

        // add r3, add r3, sub r4,r3,r3: MEM beats WB on both operands
        drive_r(5'd1, 5'd2, 5'd3);
        tick();
        drive_r(5'd1, 5'd2, 5'd3);
        tick();
        drive_r(5'd3, 5'd3, 5'd4);
        tick();
        check("mem_fwd_a",  32'(bus.ForwardA), 2);
        check("mem_fwd_b",  32'(bus.ForwardB), 2);
        check("mem_wb_reg", 32'(bus.WB_WriteReg), 3);
        drive_nop();
        tick();
        tick();
        tick();

        // Synthetic word with Branch and MemRead so flush and load-use coincide
        drive(2'd0, 0, 0, 1, 0, 1, 0, 0, 5'd1, 5'd8, 5'd0);
        tick();
        check("br_ex_branch", 32'(bus.EX_Branch), 1);
        drive_r(5'd8, 5'd2, 5'd9);
        bus.BranchTaken = 1'b1;
        #1;
        check("br_flush1",    32'(bus.FlushIFID), 1);
        check("br_pcwrite",   32'(bus.PCWrite), 1);
        check("br_ifidwrite", 32'(bus.IFIDWrite), 1);
        tick();
        check("br_ex_bubble", 32'(bus.EX_ALUOp), 3);
        check("br_ex_branch0", 32'(bus.EX_Branch), 0);
        check("br_flushcnt1", 32'(bus.FlushCount), 1);
        check("br_stallcnt",  32'(bus.StallCount), 1);
        check("br_mem_rd",    32'(bus.MEM_MemRead), 1);
        check("br_taken_ign", 32'(bus.FlushIFID), 0);
        drive_nop();
        tick();
        check("br_flushcnt_h", 32'(bus.FlushCount), 1);
        bus.BranchTaken = 1'b0;
        tick();
        tick();

        // Asynchronous reset with a store in MEM
        drive_sw(5'd1, 5'd2);
        tick();
        drive_nop();
        tick();
        check("ar_mem_wr_pre", 32'(bus.MEM_MemWrite), 1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("ar_mem_wr_async", 32'(bus.MEM_MemWrite), 0);
        check("ar_ex_aluop",     32'(bus.EX_ALUOp), 3);
        check("ar_stallcnt",     32'(bus.StallCount), 0);
        check("ar_flushcnt",     32'(bus.FlushCount), 0);
        check("ar_pcwrite",      32'(bus.PCWrite), 1);
        #3;
        Reset_n = 1'b1;
        tick();
        check("ar_post_mem_wr", 32'(bus.MEM_MemWrite), 0);
        check("ar_post_wb_rw",  32'(bus.WB_RegWrite), 0);
        tick();
        check("ar_post2_wb_rw", 32'(bus.WB_RegWrite), 0);

        // 17 load-use stalls into a 4-bit counter: saturates at 15
        for (int i = 1; i <= 17; i++) begin
            drive_lw(5'd1, 5'd8);
            tick();
            drive_r(5'd8, 5'd2, 5'd9);
            #1;
            if (i == 17) check("sat_pcwrite0", 32'(bus.PCWrite), 0);
            tick();
            if (i == 15) check("sat_stallcnt15", 32'(bus.StallCount), 15);
        end
        check("sat_stallcnt_max", 32'(bus.StallCount), 15);
        check("sat_flushcnt0",    32'(bus.FlushCount), 0);
        drive_nop();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
